inv_sbox_builder: RTL and testbench
===================================

Name: inv_sbox_builder

Overview:
- Builds the AES inverse S-box table at run time from the forward `rom_sbox` (`rom_addr` in, `data_o` out).
- Construction walk: for i = 0..255, store `inv[sbox(i)] = i` into an internal 256x8 register table.
- Then serves InvSubBytes lookups over a pipelined valid/ready interface, 1-cycle latency, throughput 1 per cycle.
- Sits beside the forward S-box path and feeds the decryption datapath.

Parameters:
- BUILD_CNT_W, 9, width of the build/check address counter (carries 0..256).

Ports:
- `clk_i` input 1: single clock, all state on rising edge.
- `reset_n_i` input 1: asynchronous, active-low reset.
- `rebuild_i` input 1: one-cycle pulse; re-runs table construction.
- `req_v_i` input 1: lookup request valid.
- `req_addr_i` input 8: byte to inverse-substitute.
- `req_ready_o` output 1: lookup accepted this cycle when `req_v_i` && `req_ready_o`.
- `resp_v_o` output 1: lookup result valid.
- `resp_data_o` output 8: inverse S-box of the accepted address.
- `table_ready_o` output 1: table complete and valid.
- `busy_o` output 1: construction (or check) in progress.
- `err_o` output 1: self-check mismatch, sticky (only driven with the optional feature).

Behaviour:
- Reset is asynchronous active-low, with this effect while `reset_n_i` is low:
  - all outputs go to 0;
  - state goes to IDLE;
  - counter goes to 0;
  - table contents are don't-care.
- FSM states are IDLE, BUILD, CHECK (optional), READY.
- IDLE: on the first cycle after reset release, go unconditionally to BUILD with the counter at 0.
- BUILD:
  - each cycle, drive `rom_addr` = counter[7:0] into an instantiated `rom_sbox`;
  - write `table[data_o]` <= counter[7:0], then counter++;
  - after the write with counter = 255 (256 cycles total), go to READY, or to CHECK when the feature is enabled;
  - `busy_o` = 1 throughout.
- READY:
  - `table_ready_o` = 1, `busy_o` = 0, `req_ready_o` = 1;
  - an accepted request registers `resp_data_o` <= `table[req_addr_i]` and `resp_v_o` <= 1 on the next edge;
  - with no request accepted, `resp_v_o` <= 0 and `resp_data_o` holds its last value;
  - back-to-back requests on consecutive cycles yield back-to-back responses;
  - there is no response backpressure.
- Outside READY:
  - `req_ready_o` = 0 and `table_ready_o` = 0;
  - `req_v_i` is ignored, with no response generated.
- `rebuild_i` in READY: on the next edge, go to BUILD with counter 0.
  - `table_ready_o` and `req_ready_o` drop that same edge.
  - A request accepted in the cycle `rebuild_i` is high is still answered from the old table.
- `rebuild_i` during BUILD/CHECK: restart BUILD from counter 0. `err_o` is not cleared.
- Reset mid-BUILD: abort immediately; BUILD restarts after release.
- Total latency from reset release to `table_ready_o` = 1 (IDLE) + 256 (BUILD) cycles = 257 cycles.
- Counter width: use bit 8 only for terminal detection. Writes use bits [7:0].

Optional Feature:
- Macro: `INV_SBOX_SELFCHECK_EN`.
- When defined:
  - after BUILD, enter CHECK for 256 cycles;
  - each cycle, drive `rom_addr` = counter[7:0] and compare `table[data_o]` against counter[7:0];
  - any mismatch sets `err_o` = 1 (sticky until reset);
  - then go to READY regardless of the result;
  - reset-to-ready latency becomes 513 cycles; `busy_o` = 1 during CHECK.
- When undefined:
  - no CHECK state, and `err_o` is tied to 0;
  - latency is 257 cycles.

Test Plan:
- Release `reset_n_i` and count cycles:
  - `busy_o` goes high next cycle;
  - `table_ready_o` rises exactly 257 cycles after release (513 with `INV_SBOX_SELFCHECK_EN`);
  - `req_ready_o` = 0 until then.
- Once ready, issue single requests:
  - 0x63 -> `resp_data_o` 0x00, one cycle later with `resp_v_o` = 1;
  - 0x7C -> 0x01;
  - 0xED -> 0x53;
  - 0x00 -> 0x52;
  - 0x16 -> 0xFF.
- Stream `req_v_i` continuously over all 256 addresses:
  - `resp_v_o` stays high for 256 consecutive cycles;
  - forward `rom_sbox` applied to each response equals the address issued one cycle earlier;
  - `err_o` = 0.
- Pulse `rebuild_i` together with a request for 0x63:
  - response 0x00 is still delivered next cycle;
  - `table_ready_o` is low for 256 cycles, then high;
  - requests during BUILD are never answered.
- Assert `reset_n_i` low asynchronously mid-BUILD (counter ~100):
  - all outputs go to 0 immediately, without waiting for a clock;
  - after release, full 257-cycle build and correct lookups.
- With `INV_SBOX_SELFCHECK_EN`, force one table entry corrupt during CHECK:
  - `err_o` = 1 and stays high through READY until reset.

Source files
------------

// File: rtl/inv_sbox_builder_if.sv
// Lookup handshake between the decryption datapath and the inverse S-box builder.
// The builder side uses the slave modport; the requester uses master.
interface inv_sbox_builder_if;
    logic       req_v_i;
    logic [7:0] req_addr_i;
    logic       req_ready_o;
    logic       resp_v_o;
    logic [7:0] resp_data_o;

    modport slave (
        input  req_v_i,
        input  req_addr_i,
        output req_ready_o,
        output resp_v_o,
        output resp_data_o
    );

    modport master (
        output req_v_i,
        output req_addr_i,
        input  req_ready_o,
        input  resp_v_o,
        input  resp_data_o
    );
endinterface

// File: rtl/inv_sbox_builder.sv
// Builds the AES inverse S-box at run time from the forward ROM, then serves lookups.
// Optional post-build table verification is enabled by defining INV_SBOX_SELFCHECK_EN.
module rom_sbox (
    input  logic [7:0] rom_addr,
    output logic [7:0] data_o
);
    localparam logic [2047:0] SBOX_ROM = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the most significant byte; ~addr*8 is its bit offset.
    assign data_o = SBOX_ROM[{~rom_addr, 3'b000} +: 8];
endmodule

module inv_sbox_builder #(
    parameter int unsigned BUILD_CNT_W = 9
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 rebuild_i,
    inv_sbox_builder_if.slave    lookup,
    output logic                 table_ready_o,
    output logic                 busy_o,
    output logic                 err_o
);
`ifdef INV_SBOX_SELFCHECK_EN
    typedef enum logic [1:0] {IDLE, BUILD, CHECK, READY} state_t;
`else
    typedef enum logic [1:0] {IDLE, BUILD, READY} state_t;
`endif

    state_t                 state_q;
    logic [BUILD_CNT_W-1:0] cnt_q;
    logic [BUILD_CNT_W-1:0] cnt_nxt;
    logic [7:0]             rom_data;
    logic [7:0]             table_q [256];
    logic                   req_ready_q;
    logic                   resp_v_q;
    logic [7:0]             resp_data_q;
    logic                   table_ready_q;
    logic                   busy_q;
    logic                   accept;

    rom_sbox u_rom (
        .rom_addr (cnt_q[7:0]),
        .data_o   (rom_data)
    );

    assign cnt_nxt = cnt_q + BUILD_CNT_W'(1);
    assign accept  = lookup.req_v_i && req_ready_q;

    // Table storage carries no reset; its contents are meaningless until BUILD completes.
    always_ff @(posedge clk_i) begin
        if (state_q == BUILD) begin
            table_q[rom_data] <= cnt_q[7:0];
        end
    end

`ifdef INV_SBOX_SELFCHECK_EN
    logic err_q;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            req_ready_q   <= 1'b0;
            resp_v_q      <= 1'b0;
            resp_data_q   <= '0;
            table_ready_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef INV_SBOX_SELFCHECK_EN
            err_q         <= 1'b0;
`endif
        end else begin
            // A request accepted alongside rebuild_i still reads the old table here.
            resp_v_q <= accept;
            if (accept) begin
                resp_data_q <= table_q[lookup.req_addr_i];
            end
            case (state_q)
                IDLE: begin
                    state_q <= BUILD;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
                BUILD: begin
                    if (rebuild_i) begin
                        cnt_q <= '0;
                    end else if (cnt_nxt[BUILD_CNT_W-1]) begin
                        cnt_q <= '0;
`ifdef INV_SBOX_SELFCHECK_EN
                        state_q <= CHECK;
`else
                        state_q       <= READY;
                        busy_q        <= 1'b0;
                        table_ready_q <= 1'b1;
                        req_ready_q   <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_nxt;
                    end
                end
`ifdef INV_SBOX_SELFCHECK_EN
                CHECK: begin
                    if (table_q[rom_data] != cnt_q[7:0]) begin
                        err_q <= 1'b1;
                    end
                    if (rebuild_i) begin
                        state_q <= BUILD;
                        cnt_q   <= '0;
                    end else if (cnt_nxt[BUILD_CNT_W-1]) begin
                        state_q       <= READY;
                        cnt_q         <= '0;
                        busy_q        <= 1'b0;
                        table_ready_q <= 1'b1;
                        req_ready_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_nxt;
                    end
                end
`endif
                READY: begin
                    if (rebuild_i) begin
                        state_q       <= BUILD;
                        cnt_q         <= '0;
                        busy_q        <= 1'b1;
                        table_ready_q <= 1'b0;
                        req_ready_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lookup.req_ready_o = req_ready_q;
    assign lookup.resp_v_o    = resp_v_q;
    assign lookup.resp_data_o = resp_data_q;
    assign table_ready_o      = table_ready_q;
    assign busy_o             = busy_q;
`ifdef INV_SBOX_SELFCHECK_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_inv_sbox_builder.sv
// Self-checking bench for inv_sbox_builder: build latency, lookups, streaming, rebuild, async reset.
module tb_inv_sbox_builder;
`ifdef INV_SBOX_SELFCHECK_EN
    localparam int LAT = 513;
    localparam int REB_LAT = 512;
`else
    localparam int LAT = 257;
    localparam int REB_LAT = 256;
`endif

    logic clk_i = 1'b0;
    logic reset_n_i = 1'b0;
    logic rebuild_i = 1'b0;
    logic table_ready_o, busy_o, err_o;

    inv_sbox_builder_if bus ();

    inv_sbox_builder #(.BUILD_CNT_W(9)) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .rebuild_i     (rebuild_i),
        .lookup        (bus),
        .table_ready_o (table_ready_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } vec_t;

    logic [7:0] tb_sbox [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] sb_q [$];
    logic [7:0] sb_addr_q [$];
    logic pend = 1'b0;
    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Accepted requests push the address issued; the response is checked the next cycle.
    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] exp);
        bus.req_v_i = v;
        bus.req_addr_i = a;
        if (v && bus.req_ready_o) begin
            sb_q.push_back(exp);
            sb_addr_q.push_back(a);
            pend = 1'b1;
        end
    endtask

    task automatic step();
        logic had;
        logic [7:0] e, a;
        had = pend;
        pend = 1'b0;
        @(posedge clk_i);
        #1;
        if (had) begin
            e = sb_q.pop_front();
            a = sb_addr_q.pop_front();
            check("resp_v", 32'(bus.resp_v_o), 32'd1);
            check("resp_data", 32'(bus.resp_data_o), 32'(e));
            check("fwd_of_resp", 32'(tb_sbox[bus.resp_data_o]), 32'(a));
        end else begin
            check("resp_idle", 32'(bus.resp_v_o), 32'd0);
        end
    endtask

    task automatic wait_ready(input int exp_lat);
        int n;
        logic bad;
        step();
        check("busy_after_release", 32'(busy_o), 32'd1);
        n = 1;
        bad = 1'b0;
        while (!table_ready_o && n < 2000) begin
            if (bus.req_ready_o) bad = 1'b1;
            step();
            n++;
        end
        check("req_ready_before_table", 32'(bad), 32'd0);
        check("build_latency", 32'(n), 32'(exp_lat));
        check("req_ready_when_ready", 32'(bus.req_ready_o), 32'd1);
        check("busy_when_ready", 32'(busy_o), 32'd0);
    endtask

    task automatic run_vectors();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, vecs[i].addr, vecs[i].exp);
            step();
            drive(1'b0, 8'h00, 8'h00);
            step();
            check("resp_data_hold", 32'(bus.resp_data_o), 32'(vecs[i].exp));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_table_ready"}, 32'(table_ready_o), 32'd0);
        check({tag, "_req_ready"}, 32'(bus.req_ready_o), 32'd0);
        check({tag, "_resp_v"}, 32'(bus.resp_v_o), 32'd0);
        check({tag, "_resp_data"}, 32'(bus.resp_data_o), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        logic [7:0] tb_inv [256];
        int n;
        for (int i = 0; i < 256; i++) tb_inv[tb_sbox[i]] = 8'(i);

        vecs[0] = '{8'h63, 8'h00};
        vecs[1] = '{8'h7c, 8'h01};
        vecs[2] = '{8'hed, 8'h53};
        vecs[3] = '{8'h00, 8'h52};
        vecs[4] = '{8'h16, 8'hff};

        bus.req_v_i = 1'b0;
        bus.req_addr_i = 8'h00;
        repeat (3) @(posedge clk_i);
        #1;
        check_outputs_zero("reset");
        reset_n_i = 1'b1;
        wait_ready(LAT);
        check("err_after_build", 32'(err_o), 32'd0);

        run_vectors();

        for (int a = 0; a < 256; a++) begin
            drive(1'b1, 8'(a), tb_inv[a]);
            step();
        end
        drive(1'b0, 8'h00, 8'h00);
        step();
        check("err_after_stream", 32'(err_o), 32'd0);

        // Rebuild with a simultaneous request: answered from the old table.
        rebuild_i = 1'b1;
        drive(1'b1, 8'h63, 8'h00);
        step();
        rebuild_i = 1'b0;
        check("rebuild_table_ready_drop", 32'(table_ready_o), 32'd0);
        check("rebuild_req_ready_drop", 32'(bus.req_ready_o), 32'd0);
        check("rebuild_busy", 32'(busy_o), 32'd1);
        n = 0;
        while (!table_ready_o && n < 2000) begin
            drive(1'b1, 8'($urandom_range(0, 255)), 8'h00);
            step();
            n++;
        end
        drive(1'b0, 8'h00, 8'h00);
        check("rebuild_latency", 32'(n), 32'(REB_LAT));
        run_vectors();

        // Asynchronous reset between clock edges in the middle of BUILD.
        rebuild_i = 1'b1;
        step();
        rebuild_i = 1'b0;
        repeat (100) step();
        #3;
        reset_n_i = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        repeat (2) @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        wait_ready(LAT);
        run_vectors();

`ifdef INV_SBOX_SELFCHECK_EN
        reset_n_i = 1'b0;
        #1;
        reset_n_i = 1'b1;
        repeat (267) step();
        check("in_check_busy", 32'(busy_o), 32'd1);
        dut.table_q[tb_sbox[200]] = 8'h00;
        n = 0;
        while (!table_ready_o && n < 2000) begin
            step();
            n++;
        end
        check("err_set", 32'(err_o), 32'd1);
        repeat (5) step();
        check("err_sticky", 32'(err_o), 32'd1);
        reset_n_i = 1'b0;
        #1;
        check("err_cleared_by_reset", 32'(err_o), 32'd0);
        reset_n_i = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
